// File: rtl/graphics_type.sv
// graphics_type: shared vertex/triangle types, area width and ctrl state encoding
package graphics_type;
    localparam int AREA_W = 23;
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vertex_3d_t;
    typedef struct packed {
        logic [9:0]         x;
        logic [9:0]         y;
        logic signed [15:0] z;
    } vertex_2d_t;
    typedef vertex_3d_t [2:0] tri_3d_t;
    typedef vertex_2d_t [2:0] tri_2d_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PROJ, ST_AREA, ST_OUT} ctrl_state_t;
endpackage

// File: rtl/projector.sv
// projector: halve x/y, offset to screen centre and clamp to 640x480; z passes through
module projector
    import graphics_type::*;
(
    input  vertex_3d_t v,
    output vertex_2d_t p
);
    logic signed [16:0] sx, sy;
    assign sx = ($signed({v.x[15], v.x}) >>> 1) + 17'sd320;
    assign sy = ($signed({v.y[15], v.y}) >>> 1) + 17'sd240;
    // clamp each screen coordinate into the visible raster
    always_comb begin
        p.x = sx < 0 ? 10'd0 : (sx > 17'sd639 ? 10'd639 : sx[9:0]);
        p.y = sy < 0 ? 10'd0 : (sy > 17'sd479 ? 10'd479 : sy[9:0]);
        p.z = v.z;
    end
endmodule

// File: rtl/tri_area.sv
// tri_area: signed double-area of a 2D triangle from its two edge vectors
module tri_area
    import graphics_type::*;
(
    input  vertex_2d_t               v0,
    input  vertex_2d_t               v1,
    input  vertex_2d_t               v2,
    output logic signed [AREA_W-1:0] area
);
    logic signed [10:0] dx1, dy1, dx2, dy2;
    assign dx1 = $signed({1'b0, v1.x}) - $signed({1'b0, v0.x});
    assign dy1 = $signed({1'b0, v1.y}) - $signed({1'b0, v0.y});
    assign dx2 = $signed({1'b0, v2.x}) - $signed({1'b0, v0.x});
    assign dy2 = $signed({1'b0, v2.y}) - $signed({1'b0, v0.y});
    assign area = AREA_W'(dx1) * AREA_W'(dy2) - AREA_W'(dx2) * AREA_W'(dy1);
endmodule

// File: rtl/tri_project_ctrl.sv
// tri_project_ctrl: projects a triangle one vertex per cycle, culls on area, hands off to raster
module tri_project_ctrl
    import graphics_type::*;
#(
    parameter bit CULL_BACK       = 1'b1,
    parameter bit CULL_DEGENERATE = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  tri_3d_t                  in_tri,
    output logic                     out_valid,
    input  logic                     out_ready,
    output tri_2d_t                  out_tri,
    output logic signed [AREA_W-1:0] out_area,
    input  logic                     clear_stats,
    output logic [CNT_W-1:0]         tri_accepted,
    output logic [CNT_W-1:0]         tri_culled
);
    ctrl_state_t              state, state_n;
    logic [1:0]               idx;
    tri_3d_t                  tri_q;
    tri_2d_t                  slot;
    vertex_2d_t               proj_v;
    logic signed [AREA_W-1:0] area;
    logic                     accept, culled;

    assign in_ready = state == ST_IDLE && !rst;
    assign accept   = in_valid && in_ready;
    assign culled   = (CULL_DEGENERATE && area == '0) || (CULL_BACK && area < 0);

    projector u_proj (.v(tri_q[idx]), .p(proj_v));

    tri_area u_area (.v0(slot[0]), .v1(slot[1]), .v2(slot[2]), .area(area));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // next-state: one pass per vertex, then a single area/cull decision cycle
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: state_n = accept ? ST_PROJ : ST_IDLE;
            ST_PROJ: state_n = idx == 2'd2 ? ST_AREA : ST_PROJ;
            ST_AREA: state_n = culled ? ST_IDLE : ST_OUT;
            ST_OUT:  state_n = out_ready ? ST_IDLE : ST_OUT;
            default: state_n = ST_IDLE;
        endcase
    end

    // datapath: latch input, fill 2D slots, register the result for the rasterizer
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_tri   <= '0;
            out_area  <= '0;
        end else begin
            if (accept) begin
                tri_q <= in_tri;
                idx   <= 2'd0;
            end
            if (state == ST_PROJ) begin
                slot[idx] <= proj_v;
                idx       <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
            end
            if (state == ST_AREA && !culled) begin
                out_tri   <= slot;
                out_area  <= area;
                out_valid <= 1'b1;
            end
            if (state == ST_OUT && out_ready) out_valid <= 1'b0;
        end
    end

    // statistics; a clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            tri_accepted <= '0;
            tri_culled   <= '0;
        end else begin
            if (accept) tri_accepted <= tri_accepted + CNT_W'(1);
            if (state == ST_AREA && culled) tri_culled <= tri_culled + CNT_W'(1);
        end
    end
endmodule
